// File: rtl/filter_peak_sequencer_pkg.sv
// Shared types and defaults for the pulse peak sequencer that follows the shaping filter.
package filter_peak_sequencer_pkg;

    localparam int SIZE_FILTER_DATA = 15;
    localparam int DATA_W           = SIZE_FILTER_DATA + 1;

    localparam int PEAK_WINDOW_DEF  = 13;
    localparam int HOLDOFF_DEF      = 16;

    typedef enum logic [2:0] {
        IDLE,
        ARMED,
        RISE,
        OUT,
        DEAD
    } peak_seq_state_t;

    // States in which a new crossing cannot be recorded.
    function automatic logic is_busy(input peak_seq_state_t s);
        return (s == RISE) || (s == OUT) || (s == DEAD);
    endfunction

endpackage

// File: rtl/filter_peak_sequencer_sat_counter.sv
// Saturating incrementer; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/filter_peak_sequencer.sv
// Arms on a rising threshold crossing, scans a fixed window for the pulse maximum,
// hands one amplitude/timestamp record per pulse over valid/ready, then enforces dead-time.
module filter_peak_sequencer
    import filter_peak_sequencer_pkg::*;
#(
    parameter int PEAK_WINDOW = PEAK_WINDOW_DEF,
    parameter int HOLDOFF     = HOLDOFF_DEF,
    parameter int TS_WIDTH    = 32,
    parameter int LOST_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  enable,
    input  logic [DATA_W-1:0]     threshold,
    input  logic [DATA_W-1:0]     filter_data,
    output logic                  event_valid,
    input  logic                  event_ready,
    output logic [DATA_W-1:0]     event_amplitude,
    output logic [TS_WIDTH-1:0]   event_time,
    output logic                  busy,
    output logic [LOST_WIDTH-1:0] lost_count
);

    localparam int WIN_W  = 8;
    localparam int HOLD_W = (HOLDOFF < 1) ? 1 : $clog2(HOLDOFF + 1);

    peak_seq_state_t     state;
    logic [DATA_W-1:0]   prev;
    logic [DATA_W-1:0]   peak;
    logic [TS_WIDTH-1:0] ts;
    logic [TS_WIDTH-1:0] peak_time;
    logic [WIN_W-1:0]    win;
    logic [HOLD_W-1:0]   hold;

    logic                crossing;
    logic                rise_hit;
    logic [DATA_W-1:0]   next_peak;
    logic [TS_WIDTH-1:0] next_time;

    assign crossing  = (filter_data > threshold) && (prev <= threshold);
    // Strict compare: on a plateau the earliest sample keeps the timestamp.
    assign rise_hit  = filter_data > peak;
    assign next_peak = rise_hit ? filter_data : peak;
    assign next_time = rise_hit ? ts : peak_time;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            prev <= '0;
            ts   <= '0;
        end else begin
            prev <= filter_data;
            ts   <= ts + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state           <= IDLE;
            peak            <= '0;
            peak_time       <= '0;
            win             <= '0;
            hold            <= '0;
            event_valid     <= 1'b0;
            event_amplitude <= '0;
            event_time      <= '0;
            busy            <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (enable)
                        state <= ARMED;
                end
                ARMED: begin
                    if (!enable) begin
                        state <= IDLE;
                    end else if (crossing) begin
                        peak      <= filter_data;
                        peak_time <= ts;
                        win       <= WIN_W'(PEAK_WINDOW - 1);
                        busy      <= 1'b1;
                        if (PEAK_WINDOW == 1) begin
                            state           <= OUT;
                            event_valid     <= 1'b1;
                            event_amplitude <= filter_data;
                            event_time      <= ts;
                        end else begin
                            state <= RISE;
                        end
                    end
                end
                RISE: begin
                    if (!enable) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else begin
                        peak      <= next_peak;
                        peak_time <= next_time;
                        win       <= win - WIN_W'(1);
                        // win==1 means this cycle carries the last sample of the window.
                        if (win == WIN_W'(1)) begin
                            state           <= OUT;
                            event_valid     <= 1'b1;
                            event_amplitude <= next_peak;
                            event_time      <= next_time;
                        end
                    end
                end
                OUT: begin
                    // A pending record is always delivered, even with enable low.
                    if (event_ready) begin
                        event_valid <= 1'b0;
                        if (!enable) begin
                            state <= IDLE;
                            busy  <= 1'b0;
                        end else if (HOLDOFF == 0) begin
                            state <= ARMED;
                            busy  <= 1'b0;
                        end else begin
                            state <= DEAD;
                            hold  <= HOLD_W'(HOLDOFF);
                        end
                    end
                end
                DEAD: begin
                    if (!enable) begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end else if (hold <= HOLD_W'(1)) begin
                        state <= ARMED;
                        busy  <= 1'b0;
                    end else begin
                        hold <= hold - HOLD_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

    sat_counter #(
        .WIDTH(LOST_WIDTH)
    ) u_lost (
        .clk  (clk),
        .reset(reset),
        .inc  (crossing && is_busy(state)),
        .count(lost_count)
    );

endmodule

// File: doc/filter_peak_sequencer.md
# filter_peak_sequencer

Event controller that sits directly behind the shaping filter. It watches the filter output stream, arms on a rising threshold crossing, tracks the pulse maximum over a fixed window, and hands one amplitude/timestamp record per pulse to the readout through a valid/ready handshake. After each pulse it enforces a dead-time and counts pulses it could not record.

## Interface
Parameters:
- PEAK_WINDOW, 13: number of samples scanned for the maximum, counted from the crossing sample; should equal filter k+l; legal range 1..255.
- HOLDOFF, 16: number of dead-time cycles after each record is accepted; 0 is legal.
- TS_WIDTH, 32: width of the free-running timestamp.
- LOST_WIDTH, 16: width of the lost-pulse counter.

Ports:
- clk, input, 1: system clock.
- reset, input, 1: asynchronous, active-low reset.
- enable, input, 1: arms the sequencer when high.
- threshold, input, SIZE_FILTER_DATA+1: trigger level, unsigned.
- filter_data, input, SIZE_FILTER_DATA+1: filter output, unsigned, one sample per clk.
- event_valid, output, 1: record available.
- event_ready, input, 1: consumer accepts the record.
- event_amplitude, output, SIZE_FILTER_DATA+1: peak value.
- event_time, output, TS_WIDTH: timestamp of the peak sample.
- busy, output, 1: high in RISE, OUT or DEAD.
- lost_count, output, LOST_WIDTH: crossings dropped while busy; saturating.

## Operation
- `prev` register holds the previous filter_data sample. It updates every cycle, including while disabled.
- `crossing` = (filter_data > threshold) && (prev <= threshold). The comparison is strict, unsigned.
- `ts` is a free-running counter. It is 0 after reset, increments every cycle, and wraps modulo 2^TS_WIDTH.
- States and transitions:
  - IDLE: enter ARMED when enable is high.
  - ARMED: on crossing, load peak = filter_data, peak_time = ts, win = PEAK_WINDOW-1, and enter RISE. If PEAK_WINDOW = 1, enter OUT directly.
  - RISE: each cycle, if filter_data > peak, update peak and peak_time (a tie keeps the earliest sample). Decrement win; when win reaches 0 after the last sample, enter OUT.
  - OUT: event_valid = 1. amplitude and time are stable until the handshake. When event_valid && event_ready, enter DEAD with hold = HOLDOFF (go straight to ARMED if HOLDOFF = 0).
  - DEAD: decrement hold each cycle; at 0, enter ARMED.
- A crossing detected while in RISE, OUT or DEAD increments lost_count, which saturates at all-ones.
- enable low:
  - In ARMED, RISE or DEAD: go to IDLE next cycle; a partial peak is discarded.
  - In OUT: the record is still delivered; after the handshake, go to IDLE.
- When the sequencer re-arms, a new record requires a fresh crossing. A signal that is still above threshold does not retrigger.
- Reset, including mid-operation, clears all state; any pending record is lost.

## Timing
- Reset values: event_valid=0, event_amplitude=0, event_time=0, busy=0, lost_count=0. State is IDLE, ts=0, prev=0.
- All outputs are registered.
- Crossing sample presented in cycle t0: busy is high from t0+1, event_valid is high from t0+PEAK_WINDOW, and event_time is in the range ts(t0) .. ts(t0+PEAK_WINDOW-1).
- The handshake completes in the cycle where event_valid && event_ready. event_valid drops the next cycle.
- Earliest re-arm is HOLDOFF+1 cycles after acceptance. Minimum pulse-to-pulse spacing with ready tied high is PEAK_WINDOW+HOLDOFF+1 cycles.
- Back-pressure: event_ready may stay low indefinitely. OUT holds its record, and crossings during that time are counted as lost.
- Simultaneous crossing and handshake in the same OUT cycle: the crossing counts as lost.

## Structure
- package_settings gains:
  - the state typedef `peak_seq_state_t` (IDLE, ARMED, RISE, OUT, DEAD);
  - default constants PEAK_WINDOW_DEF=13 and HOLDOFF_DEF=16.
- One sub-module, `sat_counter`: a parameterised-width saturating incrementer with an async active-low reset. It is used for lost_count and is reusable elsewhere.

## Test plan
- Threshold 100; single pulse 0,50,120,300,250,80,0…; PEAK_WINDOW=13, HOLDOFF=16; ready tied high → one record, amplitude 300, event_time = ts of the 300 sample, event_valid rises 13 cycles after the 120 sample.
- Same pulse with ready low for 40 cycles, and a second crossing at cycle 20 → record held stable for 40 cycles, lost_count=1, only one record emitted.
- Plateau 200,200,200 above threshold 100 → amplitude 200, event_time = ts of the first 200.
- Signal held at 500 through DEAD and re-arm → no second record until the signal drops to ≤100 and crosses again.
- enable dropped mid-RISE → no record, IDLE, busy=0. enable dropped in OUT → record still delivered, then IDLE.
- Reset asserted in OUT, then 300 forced crossings with LOST_WIDTH=8 → after reset all outputs are 0; lost_count saturates at 255.
